// File: rtl/command_issuer.sv
// command_issuer: program sequencer feeding the CONTROL decoder's command_code.
// A small program buffer is loaded while idle; on start the words are walked
// in order, one legal command per unstalled cycle, until a halt word, an
// illegal word, or the last buffer entry ends the run.
module command_issuer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_en_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [15:0]   load_data_i,
  input  logic          start_i,
  input  logic          stall_i,
  output logic [15:0]   command_code_o,
  output logic          cmd_valid_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          error_o,
  output logic [AW-1:0] pc_o,
  output logic [7:0]    issue_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] HALT_WORD  = 16'h0000;
  localparam logic [15:0] LEGAL_MAX  = 16'h0010;
  localparam logic [AW-1:0] LAST_PC  = AW'(DEPTH - 1);

  logic [15:0]   mem_q [DEPTH];

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   code_q, code_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;
  logic [7:0]    count_q, count_d;

  logic [15:0]   fetch_word;
  logic          word_is_halt;
  logic          word_is_legal;
  logic          at_last_entry;
  logic [7:0]    count_inc;

  assign fetch_word    = mem_q[pc_q];
  assign word_is_halt  = (fetch_word == HALT_WORD);
  assign word_is_legal = (fetch_word != HALT_WORD) && (fetch_word <= LEGAL_MAX);
  assign at_last_entry = (pc_q == LAST_PC);
  assign count_inc     = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  // Program memory: writable only while idle, and deliberately not cleared by reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && load_en_i && (state_q == IDLE)) begin
      mem_q[load_addr_i] <= load_data_i;
    end
  end

  // State and output registers, all returned to their reset values by rst
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      error_q <= error_d;
      count_q <= count_d;
    end
  end

  // Sequencing: everything holds by default and cmd_valid is a one-cycle strobe
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    code_d  = code_q;
    valid_d = 1'b0;
    error_d = error_q;
    count_d = count_q;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          pc_d    = '0;
          count_d = '0;
          error_d = 1'b0;
        end
      end

      RUN: begin
        if (!stall_i) begin
          if (word_is_legal) begin
            code_d  = fetch_word;
            valid_d = 1'b1;
            count_d = count_inc;
            if (at_last_entry) begin
              pc_d    = '0;
              state_d = DONE;
            end else begin
              pc_d = pc_q + AW'(1);
            end
          end else if (word_is_halt) begin
            code_d  = '0;
            state_d = DONE;
          end else begin
            code_d  = '0;
            error_d = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign command_code_o = code_q;
  assign cmd_valid_o    = valid_q;
  assign busy_o         = (state_q == RUN);
  assign done_o         = (state_q == DONE);
  assign error_o        = error_q;
  assign pc_o           = pc_q;
  assign issue_count_o  = count_q;

endmodule

// File: tb/tb_command_issuer.sv
// Testbench for command_issuer: a driver loads programs and starts runs while
// a monitor compares each issued command and each run's end state against
// expectations computed from the program contents alone.
module tb_command_issuer;

  logic        clk;
  logic        rst;
  logic        loadEn;
  logic [3:0]  loadAddr;
  logic [15:0] loadData;
  logic        start;
  logic        stall;
  logic [15:0] commandCode;
  logic        cmdValid;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  pc;
  logic [7:0]  issueCount;

  typedef struct {
    logic        err;
    logic [7:0]  cnt;
    logic [3:0]  pc;
    logic        lastValid;
    logic [15:0] code;
  } endRec_t;

  logic [15:0] modelMem [16];
  logic [15:0] tbProg [16];
  logic [15:0] expQ [$];
  endRec_t     endQ [$];

  int          checks = 0;
  int          errors = 0;
  int          issued = 0;
  bit          doneSeen = 0;
  logic        stallEdge = 1'b0;
  logic        prevDone = 1'b0;
  logic [15:0] lastCode = '0;

  command_issuer #(.DEPTH(16), .AW(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_en_i      (loadEn),
    .load_addr_i    (loadAddr),
    .load_data_i    (loadData),
    .start_i        (start),
    .stall_i        (stall),
    .command_code_o (commandCode),
    .cmd_valid_o    (cmdValid),
    .busy_o         (busy),
    .done_o         (done),
    .error_o        (error),
    .pc_o           (pc),
    .issue_count_o  (issueCount)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: walk the program as the spec describes and record what a run must produce
  function automatic void buildExpectation();
    endRec_t r;
    int n;
    r.err = 1'b0;
    r.pc = 4'd0;
    r.lastValid = 1'b0;
    r.code = 16'h0000;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (modelMem[i] == 16'h0000) begin
        r.pc = 4'(i);
        r.code = 16'h0000;
        break;
      end else if (modelMem[i] > 16'h0010) begin
        r.err = 1'b1;
        r.pc = 4'(i);
        r.code = 16'h0000;
        break;
      end else begin
        expQ.push_back(modelMem[i]);
        n++;
        r.code = modelMem[i];
        if (i == 15) begin
          r.pc = 4'd0;
          r.lastValid = 1'b1;
        end
      end
    end
    r.cnt = (n > 255) ? 8'hFF : 8'(n);
    endQ.push_back(r);
  endfunction

  // Whether the DUT was in RUN with stall asserted at this edge (pre-update values)
  always @(posedge clk) begin
    stallEdge = busy && stall;
  end

  // Monitor: compare every issued command and every run completion against the scoreboard
  always @(negedge clk) begin
    endRec_t r;
    if (cmdValid) begin
      checkOutput("valid_while_stalled", 32'(stallEdge), 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_issue", 32'(expQ.size()), 32'd1);
      end else begin
        checkOutput("issued_code", 32'(commandCode), 32'(expQ.pop_front()));
      end
      lastCode = commandCode;
      issued++;
    end else if (busy && issued > 0) begin
      checkOutput("code_held", 32'(commandCode), 32'(lastCode));
    end
    if (done) begin
      checkOutput("done_single_cycle", 32'(prevDone), 32'd0);
      checkOutput("busy_in_done", 32'(busy), 32'd0);
      if (endQ.size() == 0) begin
        checkOutput("unexpected_done", 32'(endQ.size()), 32'd1);
      end else begin
        r = endQ.pop_front();
        checkOutput("end_error", 32'(error), 32'(r.err));
        checkOutput("end_issue_count", 32'(issueCount), 32'(r.cnt));
        checkOutput("end_pc", 32'(pc), 32'(r.pc));
        checkOutput("end_valid_with_done", 32'(cmdValid), 32'(r.lastValid));
        checkOutput("end_code", 32'(commandCode), 32'(r.code));
      end
      doneSeen = 1;
    end
    prevDone = done;
  end

  // Write tbProg into the DUT (and the reference memory), one word per cycle
  task automatic loadProgram();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      loadEn = 1'b1;
      loadAddr = 4'(i);
      loadData = tbProg[i];
      modelMem[i] = tbProg[i];
    end
    @(negedge clk);
    loadEn = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_code"}, 32'(commandCode), 32'd0);
    checkOutput({tag, "_valid"}, 32'(cmdValid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
    checkOutput({tag, "_pc"}, 32'(pc), 32'd0);
    checkOutput({tag, "_count"}, 32'(issueCount), 32'd0);
  endtask

  // One run: stallMode 0 none, 1 random, 2 two stalled cycles after the first issue
  task automatic applyStimulus(input int stallMode, input bit injectIgnored, input int resetAfter,
                               input bit loadWithStart, input logic [15:0] startLoadData);
    int cycles;
    bit resetDone;
    cycles = 0;
    resetDone = 0;
    @(negedge clk);
    if (loadWithStart) begin
      loadEn = 1'b1;
      loadAddr = 4'd0;
      loadData = startLoadData;
      modelMem[0] = startLoadData;
    end
    buildExpectation();
    issued = 0;
    doneSeen = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    loadEn = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    checkOutput("error_cleared_on_start", 32'(error), 32'd0);
    checkOutput("count_cleared_on_start", 32'(issueCount), 32'd0);
    checkOutput("pc_cleared_on_start", 32'(pc), 32'd0);
    while (!doneSeen && !resetDone && cycles < 200) begin
      if (resetAfter > 0 && issued >= resetAfter) begin
        stall = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkResetOutputs("reset_mid_run");
        expQ.delete();
        endQ.delete();
        resetDone = 1;
      end else begin
        case (stallMode)
          1: stall = ($urandom_range(0, 3) == 0);
          2: stall = (cycles == 1 || cycles == 2);
          default: stall = 1'b0;
        endcase
        if (injectIgnored && cycles == 1) begin
          start = 1'b1;
          loadEn = 1'b1;
          loadAddr = 4'd2;
          loadData = 16'h0007;
        end else begin
          start = 1'b0;
          loadEn = 1'b0;
        end
        @(negedge clk);
        cycles++;
      end
    end
    stall = 1'b0;
    start = 1'b0;
    loadEn = 1'b0;
    if (!resetDone) begin
      checkOutput("run_completed", 32'(doneSeen), 32'd1);
    end
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("scoreboard_drained", 32'(expQ.size() + endQ.size()), 32'd0);
  endtask

  task automatic setProgram(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                            input logic [15:0] w3, input logic [15:0] fill);
    for (int i = 0; i < 16; i++) tbProg[i] = fill;
    tbProg[0] = w0;
    tbProg[1] = w1;
    tbProg[2] = w2;
    tbProg[3] = w3;
  endtask

  // Main sequence of directed scenarios followed by randomized programs
  initial begin
    rst = 1'b1;
    loadEn = 1'b0;
    loadAddr = '0;
    loadData = '0;
    start = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 16; i++) modelMem[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkResetOutputs("after_reset");

    $display("[TB] load and run");
    setProgram(16'h0001, 16'h0002, 16'h0003, 16'h0000, 16'h0004);
    loadProgram();
    applyStimulus(0, 0, 0, 0, 16'h0000);

    $display("[TB] stall after first issue");
    applyStimulus(2, 0, 0, 0, 16'h0000);

    $display("[TB] illegal word");
    setProgram(16'h0005, 16'h0011, 16'h0001, 16'h0000, 16'h0000);
    loadProgram();
    applyStimulus(0, 0, 0, 0, 16'h0000);
    repeat (3) begin
      @(negedge clk);
      checkOutput("error_sticky_in_idle", 32'(error), 32'd1);
    end

    $display("[TB] full buffer");
    setProgram(16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010);
    loadProgram();
    applyStimulus(0, 0, 0, 0, 16'h0000);

    $display("[TB] ignored inputs during run");
    setProgram(16'h0001, 16'h0002, 16'h0003, 16'h0000, 16'h0008);
    loadProgram();
    applyStimulus(0, 1, 0, 0, 16'h0000);
    applyStimulus(0, 0, 0, 0, 16'h0000);

    $display("[TB] reset mid-run");
    setProgram(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0000);
    tbProg[4] = 16'h0005;
    tbProg[5] = 16'h0006;
    loadProgram();
    applyStimulus(0, 0, 2, 0, 16'h0000);
    applyStimulus(0, 0, 0, 0, 16'h0000);

    $display("[TB] load together with start");
    setProgram(16'h0001, 16'h0002, 16'h0003, 16'h0000, 16'h000C);
    loadProgram();
    applyStimulus(0, 0, 0, 1, 16'h0009);

    $display("[TB] randomized programs with random stalls");
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 16; i++) begin
        int r;
        r = $urandom_range(0, 23);
        if (r == 0) tbProg[i] = 16'h0000;
        else if (r == 1) tbProg[i] = 16'($urandom_range(17, 65535));
        else tbProg[i] = 16'($urandom_range(1, 16));
      end
      loadProgram();
      applyStimulus(1, 0, 0, 0, 16'h0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/command_issuer.md
# command_issuer

Program sequencer that drives the CONTROL decoder's `command_code` input. It holds a small loadable program of 16-bit command words and, on `start`, steps through them, issuing one legal command per unstalled cycle with a valid strobe. Execution ends on a halt word, an illegal word, or the end of the program buffer. It sits upstream of CONTROL, which decodes codes 0x0001–0x0010 and disables regwrite for everything else.

## Interface
- DEPTH, 16: number of program entries (power of two, ≥2).
- AW, 4: address width, equal to log2(DEPTH).
- clk  in  1: clock, all state updates on rising edge.
- rst  in  1: synchronous, active-high reset.
- load_en  in  1: write `load_data` into program entry `load_addr`; honoured only in IDLE.
- load_addr  in  AW: program write address.
- load_data  in  16: program word.
- start  in  1: begin execution from entry 0; honoured only in IDLE.
- stall  in  1: downstream not ready; freeze sequencing.
- command_code  out  16: issued command word (registered).
- cmd_valid  out  1: `command_code` is a new command this cycle (registered).
- busy  out  1: state is RUN.
- done  out  1: high for exactly one cycle (state DONE).
- error  out  1: sticky; an illegal word terminated the last run.
- pc  out  AW: address of the next entry to issue.
- issue_count  out  8: commands issued in the current or last run, saturating at 255.

## Operation
- Legal word: 0x0001–0x0010. Halt word: 0x0000. Illegal word: 0x0011–0xFFFF.
- States: IDLE, RUN, DONE.
- IDLE:
  - `load_en` writes program memory.
  - `start` → RUN; `pc`=0, `issue_count`=0, `error`=0.
  - If `load_en` and `start` are both asserted, both take effect; the write lands before the first fetch.
- RUN, `stall`=1: `pc`, `command_code` and `issue_count` hold; `cmd_valid`=0.
- RUN, `stall`=0, with w = mem[pc]:
  - Legal, pc < DEPTH-1: `command_code`=w, `cmd_valid`=1, `pc`+1, `issue_count`+1 (saturating).
  - Legal, pc = DEPTH-1: issue as above, then → DONE. `pc` wraps to 0.
  - Halt: no issue; `cmd_valid`=0, `command_code`=0 → DONE.
  - Illegal: no issue; `cmd_valid`=0, `command_code`=0, `error`=1 → DONE.
- DONE: `cmd_valid`=0, `done`=1 → IDLE next cycle.
- Ignored inputs: `start` and `load_en` are ignored in RUN and DONE.
- Program memory is not cleared by `rst`.
- Reset values: state IDLE, `command_code`=0, `cmd_valid`=0, `busy`=0, `done`=0, `error`=0, `pc`=0, `issue_count`=0.

## Timing
- All outputs are registered.
- `busy`=(state==RUN), `done`=(state==DONE); both are registered state decodes.
- Start latency:
  - `start` sampled at edge k → `busy`=1 after edge k.
  - First `cmd_valid` after edge k+1, with `command_code`=mem[0].
- Throughput: one command per unstalled RUN cycle. `cmd_valid` is a single-cycle strobe per command, never held across a stall.
- Stall: `stall` sampled at edge e suppresses issue at e. Issue resumes at the first edge with `stall`=0.
- Halt/illegal at pc=j: the edge that evaluates j enters DONE. `done`=1 for one cycle, then IDLE.
- Last-entry issue: the edge that issues entry DEPTH-1 enters DONE. `cmd_valid`=1 and `done`=1 are visible together in that cycle.
- Reset dominates: `rst`=1 at any edge, including mid-RUN or with `start`, forces reset values at that edge.

## Test plan
- **Load and run.** Load 0x0001, 0x0002, 0x0003, 0x0000; pulse `start`.
  - `cmd_valid` is high on 3 consecutive cycles with codes 1, 2, 3.
  - `done` pulses on the next cycle; `issue_count`=3, `error`=0.
- **Stall.** Same program, `stall`=1 for 2 cycles after the first issue.
  - Code 1, then two cycles of `cmd_valid`=0 with `command_code` held at 1, then codes 2, 3.
  - `issue_count`=3.
- **Illegal word.** Program 0x0005, 0x0011.
  - Code 5 is issued; 0x0011 is not issued.
  - `error`=1 and `done` pulses; `error` stays 1 in IDLE until the next `start`.
- **Full buffer.** All 16 entries 0x0010.
  - 16 consecutive `cmd_valid` cycles; `done` rises with the 16th.
  - `pc` wraps to 0; `issue_count`=16.
- **Ignored inputs in RUN.** Assert `load_en` (addr 2, data 0x0007) and `start` mid-run of program 1, 2, 3, 0.
  - Issued sequence stays 1, 2, 3; mem[2] is still 0x0003 afterwards.
- **Reset mid-run.** Assert `rst` after the second issue.
  - Next cycle all outputs are at reset values.
  - A new `start` without reload reissues the original program.
